nonidem_access_sequencer: RTL and testbench
===========================================

# nonidem_access_sequencer

Sequences data-side memory requests in the FPGA build so accesses to non-idempotent regions (I/O below 0x8000_0000) are strictly ordered and single-outstanding. Idempotent requests pass through with a bounded outstanding count. Non-idempotent requests are captured, held until all prior traffic and the store buffer have drained, issued alone, and retired on their response or a timeout. The block sits between the load/store unit and the memory request port and uses the same region rule encoding as the CVA6 FPGA configuration.

## Interface
- AddrWidth, 64, request address width
- IdWidth, 4, transaction ID width
- NrNonIdemRules, 1, number of active rules (1..16)
- NonIdemAddrBase, 1024'(64'h0), 16 packed 64-bit bases; rule i at [i*64 +: 64]
- NonIdemLength, 1024'(64'h8000_0000), 16 packed 64-bit lengths, same packing
- MaxOutstanding, 8, idempotent in-flight limit (≥1)
- TimeoutCycles, 1024, cycles allowed for a non-idempotent response (≥2)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i / req_ready_o  in/out  1  upstream handshake
- req_addr_i  in  AddrWidth  request address
- req_we_i  in  1  write enable
- req_id_i  in  IdWidth  transaction ID
- mem_req_valid_o / mem_req_ready_i  out/in  1  downstream handshake
- mem_addr_o, mem_we_o, mem_id_o  out  AddrWidth/1/IdWidth  downstream request
- mem_rsp_valid_i  in  1  response strobe
- mem_rsp_id_i  in  IdWidth  response ID
- store_buffer_empty_i  in  1  committed store buffer empty
- flush_i  in  1  pipeline flush
- nonidem_busy_o  out  1  FSM not in IDLE
- timeout_o  out  1  one-cycle pulse on response timeout
- spurious_rsp_o  out  1  one-cycle pulse on unmatched response

## Operation
- Classification: hit if any rule i < NrNonIdemRules has base_i ≤ addr < base_i + len_i. The sum is computed at AddrWidth+1 bits (no wrap). Length 0 never hits.
- FSM states: IDLE, DRAIN, ISSUE, WAIT_RSP.
- IDLE, idempotent request: combinational pass-through of addr/we/id. mem_req_valid_o = req_valid_i && cnt < MaxOutstanding. req_ready_o = mem_req_ready_i && cnt < MaxOutstanding.
- IDLE, non-idempotent request: req_ready_o = 1 and mem_req_valid_o = 0. On the handshake, addr/we/id are captured into a holding register and the FSM moves to DRAIN.
- DRAIN: req_ready_o = 0. Moves to ISSUE when cnt == 0 && store_buffer_empty_i. flush_i in DRAIN drops the captured request and returns to IDLE, with flush taking priority over the ISSUE transition.
- ISSUE: mem_* driven from the holding register with mem_req_valid_o = 1. On mem_req_ready_i, moves to WAIT_RSP and clears the timer. flush_i is ignored because side effects cannot be cancelled.
- WAIT_RSP: req_ready_o = 0 and the timer increments each cycle.
  - A response whose ID equals the held ID returns the FSM to IDLE.
  - If the timer reaches TimeoutCycles−1 with no matching response, timeout_o pulses and the FSM returns to IDLE.
  - A matching response takes priority over the timeout in the same cycle.
- Outstanding counter cnt (width clog2(MaxOutstanding+1)):
  - +1 on each idempotent mem handshake.
  - −1 on each mem_rsp_valid_i not consumed by WAIT_RSP.
  - Simultaneous +1/−1 leaves it unchanged.
  - Decrement at 0 saturates and pulses spurious_rsp_o; a late response after a timeout lands here.
- A response with a non-matching ID in WAIT_RSP is handled by the counter rule above.

## Timing
- Reset values: FSM IDLE, cnt 0, holding register 0, timer 0. timeout_o, spurious_rsp_o and nonidem_busy_o are all 0. With no request, mem_req_valid_o and req_ready_o are 0.
- Idempotent path: zero added latency, fully combinational in IDLE.
- Non-idempotent path: accepted at cycle T; DRAIN at T+1. If the drain condition holds at T+1, mem_req_valid_o = 1 at T+2. Minimum turnaround from response to IDLE is 1 cycle.
- Downstream holds of mem_req_ready_i low keep ISSUE indefinitely; the timer does not run in ISSUE.
- timeout_o and spurious_rsp_o are registered single-cycle pulses.
- Reset asserted mid-operation returns the block to reset values immediately. The captured request is lost.

## Test plan
- Idempotent burst: 10 back-to-back requests to 0x8000_0000+ with no responses. Required: 8 accepted, req_ready_o = 0 after cnt = 8. One response re-enables exactly one acceptance.
- Non-idempotent ordering: 2 idempotent requests outstanding, store_buffer_empty_i = 0, then a write to 0x1000_0000 with ID 5. Required: mem_req_valid_o stays low until both responses arrive and store_buffer_empty_i = 1. The request is then issued 1 cycle later with ID 5.
- Completion: respond with ID 5 at 3 cycles after issue. Required: FSM back in IDLE next cycle, nonidem_busy_o = 0, and a following idempotent request passes the same cycle.
- Timeout: TimeoutCycles = 16, never respond. Required: timeout_o pulses exactly once at cycle 16 of WAIT_RSP. A late ID-5 response then pulses spurious_rsp_o and cnt stays 0.
- Flush: flush_i in DRAIN returns the FSM to IDLE with no downstream request. flush_i in WAIT_RSP has no effect.
- Boundaries: address 0x7FFF_FFFF is classified non-idempotent and 0x8000_0000 idempotent. Assert rst_ni low during ISSUE: mem_req_valid_o = 0 immediately.

Source files
------------

// File: rtl/nonidem_access_sequencer.sv
// Orders data-side memory requests: idempotent traffic passes through with a
// bounded outstanding count, non-idempotent accesses are drained and issued alone.
//
// state    | meaning
// IDLE     | pass-through; non-idempotent request is captured on handshake
// DRAIN    | wait for outstanding count 0 and store buffer empty
// ISSUE    | drive held request downstream until accepted
// WAIT_RSP | wait for matching response or timeout
module nonidem_access_sequencer #(
  parameter int unsigned AddrWidth       = 64,
  parameter int unsigned IdWidth         = 4,
  parameter int unsigned NrNonIdemRules  = 1,
  parameter logic [1023:0] NonIdemAddrBase = 1024'(64'h0),
  parameter logic [1023:0] NonIdemLength   = 1024'(64'h8000_0000),
  parameter int unsigned MaxOutstanding  = 8,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_we_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [IdWidth-1:0]   mem_id_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [IdWidth-1:0]   mem_rsp_id_i,
  input  logic                 store_buffer_empty_i,
  input  logic                 flush_i,
  output logic                 nonidem_busy_o,
  output logic                 timeout_o,
  output logic                 spurious_rsp_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned TmrW = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, WAIT_RSP} state_t;

  state_t               state;
  logic [AddrWidth-1:0] hold_addr;
  logic                 hold_we;
  logic [IdWidth-1:0]   hold_id;
  logic [CntW-1:0]      cnt;
  logic [TmrW-1:0]      timer;

  logic hit, room, idem_hs, nonidem_hs, rsp_match, rsp_dec;

  // Range check carried at AddrWidth+1 bits so base+len cannot wrap.
  always_comb begin
    logic [AddrWidth:0] addr_w, base_w, lim_w;
    hit    = 1'b0;
    addr_w = {1'b0, req_addr_i};
    for (int i = 0; i < 16; i++) begin
      base_w = {1'b0, NonIdemAddrBase[i*64 +: AddrWidth]};
      lim_w  = base_w + {1'b0, NonIdemLength[i*64 +: AddrWidth]};
      if ((i < int'(NrNonIdemRules)) && (addr_w >= base_w) && (addr_w < lim_w))
        hit = 1'b1;
    end
  end

  assign room       = cnt < CntW'(MaxOutstanding);
  assign idem_hs    = (state == IDLE) && req_valid_i && !hit && room && mem_req_ready_i;
  assign nonidem_hs = (state == IDLE) && req_valid_i && hit;
  assign rsp_match  = (state == WAIT_RSP) && mem_rsp_valid_i && (mem_rsp_id_i == hold_id);
  assign rsp_dec    = mem_rsp_valid_i && !rsp_match;

  assign nonidem_busy_o = (state != IDLE);

  always_comb begin
    req_ready_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_addr_o      = req_addr_i;
    mem_we_o        = req_we_i;
    mem_id_o        = req_id_i;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (hit) begin
            req_ready_o = 1'b1;
          end else begin
            mem_req_valid_o = room;
            req_ready_o     = mem_req_ready_i && room;
          end
        end
      end
      ISSUE: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = hold_addr;
        mem_we_o        = hold_we;
        mem_id_o        = hold_id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      hold_addr      <= '0;
      hold_we        <= 1'b0;
      hold_id        <= '0;
      cnt            <= '0;
      timer          <= '0;
      timeout_o      <= 1'b0;
      spurious_rsp_o <= 1'b0;
    end else begin
      timeout_o      <= 1'b0;
      spurious_rsp_o <= 1'b0;

      case ({idem_hs, rsp_dec})
        2'b10: cnt <= cnt + CntW'(1);
        2'b01: begin
          if (cnt == '0) spurious_rsp_o <= 1'b1;
          else           cnt <= cnt - CntW'(1);
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (nonidem_hs) begin
            hold_addr <= req_addr_i;
            hold_we   <= req_we_i;
            hold_id   <= req_id_i;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (flush_i) begin
            hold_addr <= '0;
            hold_we   <= 1'b0;
            hold_id   <= '0;
            state     <= IDLE;
          end else if ((cnt == '0) && store_buffer_empty_i) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Once visible downstream the access may have side effects, so flush is ignored.
          if (mem_req_ready_i) begin
            timer <= '0;
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_match) begin
            state <= IDLE;
          end else if (timer == TmrW'(TimeoutCycles - 1)) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + TmrW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonidem_access_sequencer.sv
// Directed bench for nonidem_access_sequencer: burst limit, ordering, completion,
// timeout, flush, address boundary and asynchronous reset.
module tb_nonidem_access_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_id_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_id_o;
  logic        mem_rsp_valid_i;
  logic [3:0]  mem_rsp_id_i;
  logic        store_buffer_empty_i;
  logic        flush_i;
  logic        nonidem_busy_o;
  logic        timeout_o;
  logic        spurious_rsp_o;

  int errors = 0;
  int checks = 0;

  nonidem_access_sequencer #(.TimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_id_i(req_id_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_id_o(mem_id_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_id_i(mem_rsp_id_i),
    .store_buffer_empty_i(store_buffer_empty_i), .flush_i(flush_i),
    .nonidem_busy_o(nonidem_busy_o), .timeout_o(timeout_o),
    .spurious_rsp_o(spurious_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0; req_id_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_id_i = '0;
    store_buffer_empty_i = 1'b1; flush_i = 1'b0;

    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_busy", nonidem_busy_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_spur", spurious_rsp_o, 0);
    chk("rst_mem_valid", mem_req_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    rst_ni = 1'b1;
    cyc();
    #1;
    chk("idle_mem_valid", mem_req_valid_o, 0);

    // Idempotent burst: only MaxOutstanding accepted
    mem_req_ready_i = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_addr_i = 64'h8000_0000 + 64'(i * 8);
      req_id_i   = 4'(i);
      #1;
      chk("burst_ready", req_ready_o, (i < 8) ? 64'd1 : 64'd0);
      chk("burst_valid", mem_req_valid_o, (i < 8) ? 64'd1 : 64'd0);
      if (i == 0) chk("burst_addr", mem_addr_o, 64'h8000_0000);
      cyc();
    end
    mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 4'd0;
    #1;
    chk("full_rsp_ready", req_ready_o, 0);
    cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("reopen_ready", req_ready_o, 1);
    cyc();
    #1;
    chk("refull_ready", req_ready_o, 0);
    req_valid_i = 1'b0; mem_rsp_valid_i = 1'b1;
    repeat (8) cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("drain_spur", spurious_rsp_o, 0);

    // Non-idempotent ordering behind two idempotent requests and a busy store buffer
    store_buffer_empty_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 64'h9000_0000; req_id_i = 4'd1;
    #1;
    chk("idem1_valid", mem_req_valid_o, 1);
    cyc();
    req_addr_i = 64'h9000_0008; req_id_i = 4'd2;
    cyc();
    req_addr_i = 64'h1000_0000; req_we_i = 1'b1; req_id_i = 4'd5;
    #1;
    chk("ni_ready", req_ready_o, 1);
    chk("ni_noissue", mem_req_valid_o, 0);
    cyc();
    req_valid_i = 1'b0; req_we_i = 1'b0;
    #1;
    chk("drain_busy", nonidem_busy_o, 1);
    chk("drain_hold0", mem_req_valid_o, 0);
    cyc();
    mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 4'd1;
    #1;
    chk("drain_hold1", mem_req_valid_o, 0);
    cyc();
    mem_rsp_id_i = 4'd2;
    #1;
    chk("drain_hold2", mem_req_valid_o, 0);
    cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("drain_sb_hold", mem_req_valid_o, 0);
    cyc();
    store_buffer_empty_i = 1'b1; mem_req_ready_i = 1'b0;
    #1;
    chk("drain_cond_cycle", mem_req_valid_o, 0);
    cyc();
    #1;
    chk("issue_valid", mem_req_valid_o, 1);
    chk("issue_id", mem_id_o, 5);
    chk("issue_addr", mem_addr_o, 64'h1000_0000);
    chk("issue_we", mem_we_o, 1);
    cyc();
    #1;
    chk("issue_hold", mem_req_valid_o, 1);
    mem_req_ready_i = 1'b1;
    cyc();
    req_valid_i = 1'b1; req_addr_i = 64'h8000_2000; req_id_i = 4'd7;
    #1;
    chk("wait_blocks_ready", req_ready_o, 0);
    chk("wait_blocks_valid", mem_req_valid_o, 0);
    cyc();
    cyc();
    mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 4'd5;
    #1;
    chk("wait_busy", nonidem_busy_o, 1);
    cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("done_busy", nonidem_busy_o, 0);
    chk("done_pass_valid", mem_req_valid_o, 1);
    chk("done_pass_ready", req_ready_o, 1);
    chk("done_spur", spurious_rsp_o, 0);
    cyc();
    req_valid_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 4'd7;
    cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("rsp7_spur", spurious_rsp_o, 0);

    // Timeout with flush in WAIT_RSP, then late responses at cnt 0
    req_valid_i = 1'b1; req_addr_i = 64'h2000_0000; req_id_i = 4'd5;
    #1;
    chk("to_ni_ready", req_ready_o, 1);
    cyc();
    req_valid_i = 1'b0;
    cyc();
    #1;
    chk("to_issue", mem_req_valid_o, 1);
    cyc();
    for (int k = 1; k <= 16; k++) begin
      flush_i = (k == 5);
      #1;
      chk("to_busy", nonidem_busy_o, 1);
      chk("to_early", timeout_o, 0);
      cyc();
    end
    flush_i = 1'b0;
    #1;
    chk("to_pulse", timeout_o, 1);
    chk("to_idle", nonidem_busy_o, 0);
    cyc();
    #1;
    chk("to_once", timeout_o, 0);
    mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 4'd5;
    cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("late_spur", spurious_rsp_o, 1);
    cyc();
    #1;
    chk("late_spur_once", spurious_rsp_o, 0);
    mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 4'd3;
    cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("cnt_sat_spur", spurious_rsp_o, 1);

    // Boundary address and flush in DRAIN (flush beats the ISSUE transition)
    store_buffer_empty_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 64'h7FFF_FFFF; req_id_i = 4'd9;
    #1;
    chk("bnd_ni_ready", req_ready_o, 1);
    chk("bnd_ni_valid", mem_req_valid_o, 0);
    cyc();
    req_valid_i = 1'b0; flush_i = 1'b1; store_buffer_empty_i = 1'b1;
    #1;
    chk("flush_drain_busy", nonidem_busy_o, 1);
    cyc();
    flush_i = 1'b0;
    #1;
    chk("flush_idle", nonidem_busy_o, 0);
    chk("flush_noreq", mem_req_valid_o, 0);
    cyc();
    #1;
    chk("flush_noreq2", mem_req_valid_o, 0);

    // Asynchronous reset while in ISSUE
    mem_req_ready_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 64'h3000; req_id_i = 4'd2;
    cyc();
    req_valid_i = 1'b0;
    cyc();
    #1;
    chk("rst_issue_valid", mem_req_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("rst_async_valid", mem_req_valid_o, 0);
    chk("rst_async_busy", nonidem_busy_o, 0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    #1;
    chk("rst_after_valid", mem_req_valid_o, 0);
    chk("rst_after_busy", nonidem_busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
